// File: rtl/rsa_exp_sched.sv
// rsa_exp_sched: modular-exponentiation sequencer driving one shared Montgomery
// multiplier. Computes o_m = y^d mod N with LSB-first square-and-multiply.
// t holds y^(2^i) in the Montgomery domain and m holds the partial result in the
// normal domain, so Mont(m,t) advances m and Mont(t,t) advances t.
module rsa_exp_sched #(
    parameter int WIDTH = 256,
    parameter int BITS  = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_t,
    input  logic [BITS-1:0]  i_d,
    input  logic [WIDTH-1:0] i_N,
    output logic [WIDTH-1:0] o_m,
    output logic             o_finished,
    output logic             o_busy,
    output logic             o_mont_start,
    output logic [WIDTH-1:0] o_mont_a,
    output logic [WIDTH-1:0] o_mont_b,
    output logic [WIDTH-1:0] o_mont_N,
    input  logic [WIDTH-1:0] i_mont_m,
    input  logic             i_mont_ready
);

    localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        BIT_CHK,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] t_reg;
    logic [BITS-1:0]  d_reg;
    logic [WIDTH-1:0] n_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The multiplier always sees the modulus latched at start.
    assign o_mont_N = n_reg;

    // Sequencer: state, operand registers and all registered outputs.
    // Outputs are updated on the transition into a state so that o_mont_start
    // is high exactly while in a *_REQ state and o_finished exactly in DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            m_reg        <= '0;
            t_reg        <= '0;
            d_reg        <= '0;
            n_reg        <= '0;
            cnt_reg      <= '0;
            o_m          <= '0;
            o_finished   <= 1'b0;
            o_busy       <= 1'b0;
            o_mont_start <= 1'b0;
            o_mont_a     <= '0;
            o_mont_b     <= '0;
        end else begin
            // Pulsed outputs default low; request operands are held so they
            // stay stable until the matching i_mont_ready.
            o_mont_start <= 1'b0;
            o_finished   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        t_reg     <= i_t;
                        d_reg     <= i_d;
                        n_reg     <= i_N;
                        m_reg     <= WIDTH'(1);
                        cnt_reg   <= '0;
                        o_busy    <= 1'b1;
                        state_reg <= BIT_CHK;
                    end
                end

                BIT_CHK: begin
                    if (d_reg[cnt_reg]) begin
                        o_mont_start <= 1'b1;
                        o_mont_a     <= m_reg;
                        o_mont_b     <= t_reg;
                        state_reg    <= MUL_REQ;
                    end else if (cnt_reg == LAST_BIT) begin
                        // Top bit is zero: the final square is never needed.
                        o_finished <= 1'b1;
                        o_m        <= m_reg;
                        state_reg  <= DONE;
                    end else begin
                        o_mont_start <= 1'b1;
                        o_mont_a     <= t_reg;
                        o_mont_b     <= t_reg;
                        state_reg    <= SQR_REQ;
                    end
                end

                MUL_REQ: begin
                    state_reg <= MUL_WAIT;
                end

                MUL_WAIT: begin
                    if (i_mont_ready) begin
                        m_reg <= i_mont_m;
                        if (cnt_reg == LAST_BIT) begin
                            // Result leaves straight from the multiplier output,
                            // which is the value m takes on this same edge.
                            o_finished <= 1'b1;
                            o_m        <= i_mont_m;
                            state_reg  <= DONE;
                        end else begin
                            o_mont_start <= 1'b1;
                            o_mont_a     <= t_reg;
                            o_mont_b     <= t_reg;
                            state_reg    <= SQR_REQ;
                        end
                    end
                end

                SQR_REQ: begin
                    state_reg <= SQR_WAIT;
                end

                SQR_WAIT: begin
                    if (i_mont_ready) begin
                        t_reg     <= i_mont_m;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        state_reg <= BIT_CHK;
                    end
                end

                DONE: begin
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_sched.sv
// Testbench for rsa_exp_sched with a behavioural Montgomery multiplier of
// programmable latency and a plain-arithmetic modular-exponentiation reference.
module tb_rsa_exp_sched;

    localparam int W = 8;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_t;
    logic [B-1:0] i_d;
    logic [W-1:0] i_N;
    logic [W-1:0] o_m;
    logic         o_finished;
    logic         o_busy;
    logic         o_mont_start;
    logic [W-1:0] o_mont_a;
    logic [W-1:0] o_mont_b;
    logic [W-1:0] o_mont_N;
    logic [W-1:0] i_mont_m;
    logic         i_mont_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rsa_exp_sched #(.WIDTH(W), .BITS(B)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_t          (i_t),
        .i_d          (i_d),
        .i_N          (i_N),
        .o_m          (o_m),
        .o_finished   (o_finished),
        .o_busy       (o_busy),
        .o_mont_start (o_mont_start),
        .o_mont_a     (o_mont_a),
        .o_mont_b     (o_mont_b),
        .o_mont_N     (o_mont_N),
        .i_mont_m     (i_mont_m),
        .i_mont_ready (i_mont_ready)
    );

    // Mont(a,b) = a*b*2^-W mod n, with 2^-W found by search.
    function automatic longint mont(input longint a, input longint b, input longint n);
        longint rinv;
        rinv = 0;
        for (longint x = 1; x < n; x++) begin
            if (((x << W) % n) == 1) begin
                rinv = x;
                break;
            end
        end
        return (((a * b) % n) * rinv) % n;
    endfunction

    // Golden y^e mod n by ordinary modular exponentiation.
    function automatic longint mod_pow(input longint y, input longint e, input longint n);
        longint r;
        longint base;
        r = 1 % n;
        base = y % n;
        for (int i = 0; i < B; i++) begin
            if (((e >> i) & 1) == 1) r = (r * base) % n;
            base = (base * base) % n;
        end
        return r;
    endfunction

    // Runs one operation, acting as the multiplier; checks protocol and request order.
    task automatic do_op(input logic [W-1:0] t, input logic [B-1:0] d, input logic [W-1:0] n,
                         input int lat, input bit glitch, output logic [W-1:0] res);
        logic [W-1:0] ea[$];
        logic [W-1:0] eb[$];
        logic [W-1:0] ga[$];
        logic [W-1:0] gb[$];
        longint mm;
        longint tt;
        logic [W-1:0] hold_a;
        logic [W-1:0] hold_b;
        bit pending;
        bit prev_start;
        bit fin;
        bit stray_done;
        bit seq_ok;
        int wcnt;

        // Expected request list straight from the square-and-multiply rule.
        mm = 1;
        tt = longint'(t);
        for (int i = 0; i < B; i++) begin
            if (d[i]) begin
                ea.push_back(W'(mm));
                eb.push_back(W'(tt));
                mm = mont(mm, tt, longint'(n));
            end
            if (i < B - 1) begin
                ea.push_back(W'(tt));
                eb.push_back(W'(tt));
                tt = mont(tt, tt, longint'(n));
            end
        end

        res = '0;
        pending = 1'b0;
        prev_start = 1'b0;
        fin = 1'b0;
        stray_done = 1'b0;
        wcnt = 0;
        hold_a = '0;
        hold_b = '0;

        @(negedge clk);
        i_t = t;
        i_d = d;
        i_N = n;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;

        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            i_mont_ready = 1'b0;
            i_start = 1'b0;

            if (o_mont_start) begin
                n_cmp++;
                if (prev_start || pending) begin
                    n_err++;
                    $display("FAIL start_pulse: got start=1 prev_start=%0d pending=%0d required a single pulse with nothing outstanding",
                             prev_start, pending);
                end
                n_cmp++;
                if (o_mont_N !== n) begin
                    n_err++;
                    $display("FAIL mont_N: got %0d required %0d", o_mont_N, n);
                end
                ga.push_back(o_mont_a);
                gb.push_back(o_mont_b);
                hold_a = o_mont_a;
                hold_b = o_mont_b;
                pending = 1'b1;
                wcnt = lat;
                // Stray ready while the scheduler sits in a REQ state must be ignored.
                if (glitch && !stray_done && o_mont_a == o_mont_b) begin
                    i_mont_ready = 1'b1;
                    i_mont_m = W'($urandom);
                    stray_done = 1'b1;
                end
            end else if (pending) begin
                n_cmp++;
                if (o_mont_a !== hold_a || o_mont_b !== hold_b) begin
                    n_err++;
                    $display("FAIL operand_hold: got a=%0d b=%0d required a=%0d b=%0d",
                             o_mont_a, o_mont_b, hold_a, hold_b);
                end
                wcnt--;
                if (wcnt <= 0) begin
                    i_mont_ready = 1'b1;
                    i_mont_m = W'(mont(longint'(hold_a), longint'(hold_b), longint'(n)));
                    pending = 1'b0;
                end
            end
            prev_start = o_mont_start;

            n_cmp++;
            if (o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy: got %0d required 1 at cycle %0d of op", o_busy, cyc);
            end

            if (glitch && cyc == 3) begin
                i_start = 1'b1;
                i_t = W'($urandom);
                i_d = B'($urandom);
                i_N = W'($urandom) | W'(1);
            end

            if (o_finished) begin
                fin = 1'b1;
                res = o_m;
                // A start landing in DONE must also be ignored.
                if (glitch) i_start = 1'b1;
            end
        end

        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL timeout: got no o_finished within 5000 cycles, required one");
        end

        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_mont_ready = 1'b0;
        n_cmp++;
        if (o_finished !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL finish_pulse: got finished=%0d busy=%0d required 0 0", o_finished, o_busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_mont_start !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after: got busy=%0d start=%0d required 0 0", o_busy, o_mont_start);
        end

        seq_ok = (ga.size() == ea.size());
        if (seq_ok) begin
            foreach (ea[i]) begin
                if (ga[i] !== ea[i] || gb[i] !== eb[i]) seq_ok = 1'b0;
            end
        end
        n_cmp++;
        if (!seq_ok) begin
            n_err++;
            $display("FAIL req_seq: got %0d requests required %0d (t=%0d d=%0d N=%0d)",
                     ga.size(), ea.size(), t, d, n);
        end

        $display("op t=%0d d=%0d N=%0d lat=%0d glitch=%0d -> o_m=%0d reqs=%0d",
                 t, d, n, lat, glitch, res, ga.size());
    endtask

    task automatic check_result(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (o_m !== '0 || o_finished !== 1'b0 || o_busy !== 1'b0 || o_mont_start !== 1'b0 ||
            o_mont_a !== '0 || o_mont_b !== '0 || o_mont_N !== '0) begin
            n_err++;
            $display("FAIL reset_state: got m=%0d fin=%0d busy=%0d st=%0d a=%0d b=%0d N=%0d required all 0",
                     o_m, o_finished, o_busy, o_mont_start, o_mont_a, o_mont_b, o_mont_N);
        end
        @(negedge clk);
        i_rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_case1();
        logic [W-1:0] r;
        do_op(8'd158, 4'b0111, 8'd187, 2, 1'b0, r);
        check_result("case1_result", r, 8'd146);
    endtask

    task automatic test_zero_exp();
        logic [W-1:0] r;
        do_op(8'd158, 4'b0000, 8'd187, 3, 1'b0, r);
        check_result("zero_exp_result", r, 8'd1);
    endtask

    task automatic test_glitch();
        logic [W-1:0] r;
        do_op(8'd158, 4'b0111, 8'd187, 3, 1'b1, r);
        check_result("glitch_result", r, 8'd146);
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] r;
        bit found;
        bit bad;
        found = 1'b0;
        bad = 1'b0;
        @(negedge clk);
        i_t = 8'd158;
        i_d = 4'b0111;
        i_N = 8'd187;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            if (o_mont_start) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL abort_req: got no request within 50 cycles, required one");
        end
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_m !== '0 || o_finished !== 1'b0 || o_busy !== 1'b0 || o_mont_start !== 1'b0 ||
            o_mont_a !== '0 || o_mont_b !== '0 || o_mont_N !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got m=%0d fin=%0d busy=%0d st=%0d a=%0d b=%0d N=%0d required all 0",
                     o_m, o_finished, o_busy, o_mont_start, o_mont_a, o_mont_b, o_mont_N);
        end
        @(negedge clk);
        i_rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (o_finished !== 1'b0 || o_busy !== 1'b0 || o_mont_start !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL abort_quiet: got activity after reset abort, required none");
        end
        $display("abort during MUL_WAIT done");
        do_op(8'd158, 4'b0111, 8'd187, 2, 1'b0, r);
        check_result("after_abort_result", r, 8'd146);
    endtask

    task automatic test_latency();
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        do_op(8'd158, 4'b0111, 8'd187, 1, 1'b0, r1);
        do_op(8'd158, 4'b0111, 8'd187, 300, 1'b0, r2);
        check_result("lat1_result", r1, 8'd146);
        check_result("lat300_result", r2, 8'd146);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r;
        logic [W-1:0] n;
        logic [W-1:0] y;
        logic [W-1:0] t;
        logic [B-1:0] d;
        logic [W-1:0] exp;
        for (int k = 0; k < 8; k++) begin
            n = W'(2 * $urandom_range(1, 127) + 1);
            y = W'($urandom_range(0, int'(n) - 1));
            t = W'((longint'(y) << W) % longint'(n));
            d = B'($urandom);
            exp = W'(mod_pow(longint'(y), longint'(d), longint'(n)));
            do_op(t, d, n, int'($urandom_range(1, 6)), 1'b0, r);
            check_result("random_result", r, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_t = '0;
        i_d = '0;
        i_N = '0;
        i_mont_m = '0;
        i_mont_ready = 1'b0;

        test_reset();
        test_case1();
        test_zero_exp();
        test_glitch();
        test_reset_abort();
        test_latency();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
